acc_result_stage: RTL
=====================

Name: acc_result_stage

Overview:
- Sequential stage wrapped around the 3-bit ripple full adder (inputs A1..A3, B1..B3; outputs S1..S3, Carry; LSB is index 1).
- Drives the adder's A operand from an internal 3-bit accumulator and its B operand from a latched input word.
- Waits a programmable number of cycles for the ripple chain to settle, then captures {Carry,S3,S2,S1}.
- Updates the accumulator and presents the 4-bit result downstream with a valid/ready handshake.

Parameters:
- SETTLE_CYC, 2, cycles between driving new operands and sampling the adder outputs. Legal range 1..15.
- CNT_W, 4, width of the operation counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  stage can accept a request
- in_op  input  1  0 = ADD (acc + in_b), 1 = LOAD (acc <= in_b, adder bypassed)
- in_b  input  3  operand B
- clear  input  1  synchronous clear of acc, ovf_sticky and op_count
- adder_a  output  3  to A3..A1 (bit0 -> A1)
- adder_b  output  3  to B3..B1 (bit0 -> B1)
- adder_s  input  3  from S3..S1 (bit0 = S1)
- adder_c  input  1  from Carry
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_sum  output  4  {carry, sum[2:0]}; for LOAD this is {0, in_b}
- ovf_sticky  output  1  set when any ADD produced carry = 1
- op_count  output  CNT_W  completed operations, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst = 1 at a clk edge) overrides everything, including an operation in flight. All state returns to IDLE:
  - acc = 0, adder_a = 0, adder_b = 0.
  - out_sum = 0, out_valid = 0, in_ready = 1.
  - ovf_sticky = 0, op_count = 0, settle counter = 0.
- adder_a is always equal to acc. adder_b is always equal to the latched B register.
- FSM states: IDLE, SETTLE, CAPTURE, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch in_b into B_reg and latch in_op.
  - ADD goes to SETTLE with the counter loaded to SETTLE_CYC-1.
  - LOAD goes directly to CAPTURE.
- SETTLE:
  - in_ready = 0; the counter decrements each cycle.
  - At count 0, go to CAPTURE.
  - The first capture therefore happens SETTLE_CYC cycles after the accept edge.
  - Minimum ADD latency from accept to out_valid = SETTLE_CYC + 1 cycles.
- CAPTURE (one cycle), ADD:
  - out_sum <= {adder_c, adder_s}; acc <= adder_s.
  - ovf_sticky <= ovf_sticky | adder_c.
  - op_count <= op_count + 1. Go to OUT.
- CAPTURE, LOAD:
  - out_sum <= {1'b0, B_reg}; acc <= B_reg.
  - ovf_sticky unchanged; op_count increments. Go to OUT.
  - LOAD latency from accept to out_valid = 2 cycles.
- OUT:
  - out_valid = 1; out_sum is held stable while out_ready = 0.
  - When out_valid and out_ready are both high at an edge, go to IDLE and drop out_valid.
  - in_ready rises on the next cycle. There is no same-cycle re-accept (no bypass).
- in_valid while in_ready = 0 is ignored. The requester must hold it until accepted.
- clear:
  - Honoured in any state; priority below rst.
  - Sets acc = 0, ovf_sticky = 0, op_count = 0, and forces IDLE with out_valid = 0. A pending result is discarded.
  - If clear and in_valid are both high in IDLE, clear wins and the request is not accepted.
- Arithmetic:
  - The adder result is modulo 8 with carry in out_sum[3].
  - acc keeps only the low 3 bits (wrap-around).
  - op_count wraps from 2^CNT_W-1 to 0 with no flag.
- The adder inputs change only on the accept edge and on the CAPTURE edge, so sampling after SETTLE_CYC cycles sees stable ripple outputs.

Test Plan:
- After reset: LOAD in_b = 5 -> out_valid 2 cycles after accept, out_sum = 0101, acc = adder_a = 5, op_count = 1, ovf_sticky = 0.
- From acc = 5: ADD in_b = 2 with SETTLE_CYC = 2 -> out_valid 3 cycles after accept, out_sum = 0111, acc = 7, ovf_sticky = 0.
- From acc = 7: ADD in_b = 3 -> out_sum = 1010, acc = 2, ovf_sticky = 1. Then ADD in_b = 1 -> out_sum = 0011, and ovf_sticky stays 1.
- Hold out_ready = 0 for 5 cycles in OUT while toggling in_valid -> out_sum stable, in_ready = 0, no second accept. out_ready = 1 -> IDLE, in_ready = 1 on the next cycle.
- Assert rst during SETTLE, and separately clear during OUT -> next cycle: IDLE, out_valid = 0, acc = 0, op_count = 0, ovf_sticky = 0.
- Issue 17 back-to-back LOADs with CNT_W = 4 -> op_count reads 1 after the final one (wrap-around). Also clear + in_valid in the same IDLE cycle -> no accept, op_count = 0.

Source files
------------

// File: rtl/acc_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : acc_result_stage
// Brief    : Accumulator/result stage wrapped around an external 3-bit ripple
//            adder, with settle wait and valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module acc_result_stage #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [2:0]       in_b,
    input  logic             clear,
    output logic [2:0]       adder_a,
    output logic [2:0]       adder_b,
    input  logic [2:0]       adder_s,
    input  logic             adder_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sum,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    localparam logic [3:0]       c_settle_load = 4'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_acc;
    logic [2:0]       r_b;
    logic             r_op;
    logic [3:0]       r_settle;
    logic [3:0]       r_sum;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && in_valid && !clear;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = in_op ? S_CAPTURE : S_SETTLE;
            S_SETTLE:  if (r_settle == 4'd0) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_OUT;
            S_OUT:     if (out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        // clear abandons any operation in flight, including a pending result
        if (clear) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= 3'd0;
            r_b      <= 3'd0;
            r_op     <= 1'b0;
            r_settle <= 4'd0;
            r_sum    <= 4'd0;
            r_ovf    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (clear) begin
                r_acc   <= 3'd0;
                r_ovf   <= 1'b0;
                r_count <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid) begin
                            r_b      <= in_b;
                            r_op     <= in_op;
                            r_settle <= c_settle_load;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
                    end
                    S_CAPTURE: begin
                        if (r_op) begin
                            r_sum <= {1'b0, r_b};
                            r_acc <= r_b;
                        end else begin
                            r_sum <= {adder_c, adder_s};
                            r_acc <= adder_s;
                            r_ovf <= r_ovf | adder_c;
                        end
                        r_count <= r_count + c_cnt_one;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign adder_a    = r_acc;
    assign adder_b    = r_b;
    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_OUT);
    assign out_sum    = r_sum;
    assign ovf_sticky = r_ovf;
    assign op_count   = r_count;

endmodule
`default_nettype wire
